quad_steer_mc: RTL and testbench



---
 rtl/quad_steer_mc_if.sv | 27 ++
 rtl/quad_steer_mc.sv | 159 +++++++++++++++
 tb/tb_quad_steer_mc.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_steer_mc_if.sv
// Bus bundle for quad_steer_mc: shared rate controls, per-channel button levels
// and the registered quadrature/position outputs.
interface quad_steer_mc_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16
);
  logic [DIV_W-1:0]      clkdiv;
  logic                  accel_en;
  logic [CHANNELS-1:0]   left;
  logic [CHANNELS-1:0]   right;
  logic [CHANNELS-1:0]   invert;
  logic [2*CHANNELS-1:0] steer;
  logic [8*CHANNELS-1:0] pos;
  logic [CHANNELS-1:0]   moving;

  // Input mapping logic side
  modport master (
    output clkdiv, accel_en, left, right, invert,
    input  steer, pos, moving
  );

  // Encoder side
  modport slave (
    input  clkdiv, accel_en, left, right, invert,
    output steer, pos, moving
  );
endinterface

// File: rtl/quad_steer_mc.sv
// Multi-channel button-to-quadrature steering encoder with per-channel invert,
// hold-to-accelerate rate ramp and a wrapping 8-bit position counter.
module quad_steer_mc #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned ACCEL_LEVELS = 4,
  parameter int unsigned ACCEL_HOLD   = 8
) (
  input logic            CLK,
  input logic            reset,
  quad_steer_mc_if.slave bus
);

  localparam int unsigned LvlW  = (ACCEL_LEVELS > 1) ? $clog2(ACCEL_LEVELS) : 1;
  localparam int unsigned HoldW = (ACCEL_HOLD > 0) ? $clog2(ACCEL_HOLD + 1) : 1;
  localparam logic [LvlW-1:0]  LvlMax  = LvlW'(ACCEL_LEVELS - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(ACCEL_HOLD);

  typedef enum logic [1:0] {
    DirNone = 2'b00,
    DirPos  = 2'b01,
    DirNeg  = 2'b10
  } dir_e;

  // Gray sequence 00 -> 01 -> 11 -> 10 -> 00 going forward
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
    logic [1:0] res;
    case (ph)
      2'b00:   res = fwd ? 2'b01 : 2'b10;
      2'b01:   res = fwd ? 2'b11 : 2'b00;
      2'b11:   res = fwd ? 2'b10 : 2'b01;
      default: res = fwd ? 2'b00 : 2'b11;
    endcase
    return res;
  endfunction

  logic [1:0]       phase_q  [CHANNELS];
  logic [1:0]       phase_d  [CHANNELS];
  logic [7:0]       pos_q    [CHANNELS];
  logic [7:0]       pos_d    [CHANNELS];
  logic             moving_q [CHANNELS];
  logic             moving_d [CHANNELS];
  logic [DIV_W-1:0] cnt_q    [CHANNELS];
  logic [DIV_W-1:0] cnt_d    [CHANNELS];
  logic [LvlW-1:0]  lvl_q    [CHANNELS];
  logic [LvlW-1:0]  lvl_d    [CHANNELS];
  logic [HoldW-1:0] hold_q   [CHANNELS];
  logic [HoldW-1:0] hold_d   [CHANNELS];
  dir_e             prev_q   [CHANNELS];
  dir_e             dir      [CHANNELS];
  logic [DIV_W-1:0] period   [CHANNELS];
  logic             step     [CHANNELS];
  logic             eff_l    [CHANNELS];
  logic             eff_r    [CHANNELS];

  // Per-channel direction decode, step timing, ramp and next phase/position
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      eff_l[c]    = bus.invert[c] ? bus.right[c] : bus.left[c];
      eff_r[c]    = bus.invert[c] ? bus.left[c]  : bus.right[c];
      dir[c]      = DirNone;
      step[c]     = 1'b0;
      cnt_d[c]    = cnt_q[c];
      lvl_d[c]    = lvl_q[c];
      hold_d[c]   = hold_q[c];
      moving_d[c] = 1'b1;

      if (eff_r[c] && !eff_l[c]) begin
        dir[c] = DirPos;
      end else if (eff_l[c] && !eff_r[c]) begin
        dir[c] = DirNeg;
      end

      // A zero period would never expire; clamp to one cycle
      period[c] = bus.clkdiv >> lvl_q[c];
      if (period[c] == '0) begin
        period[c] = DIV_W'(1);
      end

      if (dir[c] == DirNone) begin
        cnt_d[c]    = '0;
        lvl_d[c]    = '0;
        hold_d[c]   = '0;
        moving_d[c] = 1'b0;
      end else if (dir[c] != prev_q[c]) begin
        // Fresh press or reversal steps at once and restarts the ramp
        step[c]   = 1'b1;
        cnt_d[c]  = '0;
        lvl_d[c]  = '0;
        hold_d[c] = '0;
      end else begin
        // >= so a shrinking period mid-count fires next edge instead of wrapping
        if (cnt_q[c] >= period[c] - DIV_W'(1)) begin
          step[c]  = 1'b1;
          cnt_d[c] = '0;
          if (hold_q[c] != HoldMax) begin
            hold_d[c] = hold_q[c] + 1'b1;
          end
          if (hold_d[c] == HoldMax && bus.accel_en && lvl_q[c] < LvlMax) begin
            lvl_d[c]  = lvl_q[c] + 1'b1;
            hold_d[c] = '0;
          end
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
        if (!bus.accel_en) begin
          lvl_d[c] = '0;
        end
      end

      phase_d[c] = step[c] ? next_phase(phase_q[c], dir[c] == DirPos) : phase_q[c];
      if (!step[c]) begin
        pos_d[c] = pos_q[c];
      end else if (dir[c] == DirPos) begin
        pos_d[c] = pos_q[c] + 8'd1;
      end else begin
        pos_d[c] = pos_q[c] - 8'd1;
      end
    end
  end

  // Channel state registers; reset clears everything asynchronously
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c]  <= 2'b00;
        pos_q[c]    <= '0;
        moving_q[c] <= 1'b0;
        cnt_q[c]    <= '0;
        lvl_q[c]    <= '0;
        hold_q[c]   <= '0;
        prev_q[c]   <= DirNone;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_q[c]  <= phase_d[c];
        pos_q[c]    <= pos_d[c];
        moving_q[c] <= moving_d[c];
        cnt_q[c]    <= cnt_d[c];
        lvl_q[c]    <= lvl_d[c];
        hold_q[c]   <= hold_d[c];
        prev_q[c]   <= dir[c];
      end
    end
  end

  // Pack registered channel state onto the output buses
  always_comb begin
    bus.steer  = '0;
    bus.pos    = '0;
    bus.moving = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.steer[2*c +: 2] = phase_q[c];
      bus.pos[8*c +: 8]   = pos_q[c];
      bus.moving[c]       = moving_q[c];
    end
  end

endmodule

// File: tb/tb_quad_steer_mc.sv
// Directed bench for quad_steer_mc: a behavioural model predicts each edge's
// outputs into a queue, compared after the edge, plus fixed-value spot checks.
module tb_quad_steer_mc;
  localparam int unsigned CH     = 2;
  localparam int unsigned DW     = 16;
  localparam int unsigned LEVELS = 4;
  localparam int unsigned HOLD   = 8;

  typedef struct packed {
    logic [2*CH-1:0] steer;
    logic [8*CH-1:0] pos;
    logic [CH-1:0]   moving;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Model state
  int m_idx  [CH];
  int m_pos  [CH];
  int m_mov  [CH];
  int m_cnt  [CH];
  int m_lvl  [CH];
  int m_hold [CH];
  int m_prev [CH];
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_steer_mc_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

  quad_steer_mc #(
    .CHANNELS    (CH),
    .DIV_W       (DW),
    .ACCEL_LEVELS(LEVELS),
    .ACCEL_HOLD  (HOLD)
  ) dut (
    .CLK  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_idx[c] = 0; m_pos[c] = 0; m_mov[c] = 0; m_cnt[c] = 0;
      m_lvl[c] = 0; m_hold[c] = 0; m_prev[c] = 0;
    end
    sb_q.delete();
  endtask

  task automatic model_step(input int c, input int d);
    m_idx[c] = (m_idx[c] + d + 4) % 4;
    m_pos[c] = (m_pos[c] + d + 256) % 256;
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      logic l, r;
      int d, p;
      l = bus.invert[c] ? bus.right[c] : bus.left[c];
      r = bus.invert[c] ? bus.left[c] : bus.right[c];
      d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      if (d == 0) begin
        m_cnt[c] = 0; m_lvl[c] = 0; m_hold[c] = 0; m_mov[c] = 0;
      end else if (d != m_prev[c]) begin
        model_step(c, d);
        m_cnt[c] = 0; m_lvl[c] = 0; m_hold[c] = 0; m_mov[c] = 1;
      end else begin
        m_mov[c] = 1;
        p = int'(bus.clkdiv) >> m_lvl[c];
        if (p < 1) p = 1;
        if (m_cnt[c] >= p - 1) begin
          model_step(c, d);
          m_cnt[c] = 0;
          m_hold[c]++;
          if (m_hold[c] >= HOLD && bus.accel_en && m_lvl[c] < LEVELS - 1) begin
            m_lvl[c]++;
            m_hold[c] = 0;
          end
        end else begin
          m_cnt[c]++;
        end
        if (!bus.accel_en) m_lvl[c] = 0;
      end
      m_prev[c] = d;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      e.steer[2*c +: 2] = gray[m_idx[c]];
      e.pos[8*c +: 8]   = 8'(m_pos[c]);
      e.moving[c]       = (m_mov[c] != 0);
    end
    return e;
  endfunction

  // Predict, clock one edge, then compare on the falling edge
  task automatic tick();
    exp_t e;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("sb_steer", 32'(bus.steer), 32'(e.steer));
    chk("sb_pos", 32'(bus.pos), 32'(e.pos));
    chk("sb_moving", 32'(bus.moving), 32'(e.moving));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.clkdiv   = 16'd4;
    bus.accel_en = 1'b0;
    bus.left     = '0;
    bus.right    = '0;
    bus.invert   = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_steer", 32'(bus.steer), 32'h0);
    chk("reset_pos", 32'(bus.pos), 32'h0);
    chk("reset_moving", 32'(bus.moving), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic forward stepping at period 4
    bus.right = 2'b01;
    tick();
    chk("t1_steer0_first", 32'(bus.steer[1:0]), 32'h1);
    chk("t1_pos0_first", 32'(bus.pos[7:0]), 32'h1);
    ticks(4);
    chk("t1_steer0_2", 32'(bus.steer[1:0]), 32'h3);
    chk("t1_pos0_2", 32'(bus.pos[7:0]), 32'h2);
    ticks(4);
    chk("t1_steer0_3", 32'(bus.steer[1:0]), 32'h2);
    ticks(4);
    chk("t1_steer0_4", 32'(bus.steer[1:0]), 32'h0);
    chk("t1_pos0_4", 32'(bus.pos[7:0]), 32'h4);
    chk("t1_ch1_idle", 32'({bus.steer[3:2], bus.pos[15:8]}), 32'h0);
    bus.right = 2'b00;
    ticks(2);

    // Acceleration ramp: 16, 8, 4 then 2
    do_reset();
    bus.clkdiv   = 16'd16;
    bus.accel_en = 1'b1;
    bus.right    = 2'b01;
    ticks(241);
    chk("t2_pos_ramp", 32'(bus.pos[7:0]), 32'd33);
    tick();
    chk("t2_no_step", 32'(bus.pos[7:0]), 32'd33);
    tick();
    chk("t2_period2", 32'(bus.pos[7:0]), 32'd34);
    bus.right = 2'b00;
    tick();
    chk("t2_release_moving", 32'(bus.moving[0]), 32'h0);
    bus.right = 2'b01;
    tick();
    chk("t2_repress", 32'(bus.pos[7:0]), 32'd35);
    ticks(15);
    chk("t2_slow_again", 32'(bus.pos[7:0]), 32'd35);
    tick();
    chk("t2_slow_step", 32'(bus.pos[7:0]), 32'd36);

    // Reversal and both-pressed release
    do_reset();
    bus.clkdiv   = 16'd4;
    bus.accel_en = 1'b0;
    bus.right    = 2'b01;
    ticks(5);
    chk("t3_at_11", 32'(bus.steer[1:0]), 32'h3);
    ticks(2);
    bus.right = 2'b00;
    bus.left  = 2'b01;
    tick();
    chk("t3_rev_steer", 32'(bus.steer[1:0]), 32'h1);
    chk("t3_rev_pos", 32'(bus.pos[7:0]), 32'h1);
    ticks(3);
    chk("t3_rev_cnt_clear", 32'(bus.pos[7:0]), 32'h1);
    tick();
    chk("t3_rev_timed", 32'(bus.steer[1:0]), 32'h0);
    bus.right = 2'b01;
    ticks(3);
    chk("t3_both_steer", 32'(bus.steer[1:0]), 32'h0);
    chk("t3_both_moving", 32'(bus.moving[0]), 32'h0);

    // clkdiv=0 steps every edge; position wraps through +127/-128
    do_reset();
    bus.clkdiv = 16'd0;
    bus.left   = 2'b00;
    bus.right  = 2'b01;
    ticks(126);
    chk("t4_pos126", 32'(bus.pos[7:0]), 32'd126);
    tick();
    chk("t4_pos127", 32'(bus.pos[7:0]), 32'h7f);
    tick();
    chk("t4_pos_m128", 32'(bus.pos[7:0]), 32'h80);
    tick();
    chk("t4_pos_m127", 32'(bus.pos[7:0]), 32'h81);
    chk("t4_steer", 32'(bus.steer[1:0]), 32'h1);

    // Invert on channel 1 only, both channels pressing left
    do_reset();
    bus.clkdiv = 16'd4;
    bus.right  = 2'b00;
    bus.invert = 2'b10;
    bus.left   = 2'b11;
    tick();
    chk("t5_steer_first", 32'(bus.steer), 32'h6);
    chk("t5_pos_first", 32'(bus.pos), 32'h01ff);
    ticks(4);
    chk("t5_steer_second", 32'(bus.steer), 32'hf);
    chk("t5_pos_second", 32'(bus.pos), 32'h02fe);

    // Asynchronous reset between edges
    bus.invert = 2'b00;
    bus.left   = 2'b00;
    bus.right  = 2'b01;
    ticks(3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_steer", 32'(bus.steer), 32'h0);
    chk("t6_async_pos", 32'(bus.pos), 32'h0);
    chk("t6_async_moving", 32'(bus.moving), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    chk("t6_first_step", 32'(bus.steer[1:0]), 32'h1);
    chk("t6_first_pos", 32'(bus.pos[7:0]), 32'h1);
    chk("t6_first_moving", 32'(bus.moving[0]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
